// File: rtl/uart_cmd_parser_if.sv
// Bundles the RX-FIFO pop side and the command/error output side of
// uart_cmd_parser. The parser takes the master view; the surrounding logic
// (uart_core FIFO plus application consumer) takes the slave view.
interface uart_cmd_parser_if #(
    parameter int WIDTH       = 8,
    parameter int MAX_PAYLOAD = 8
);
    // RX FIFO pop handshake
    logic                         read_uart;
    logic [WIDTH-1:0]             read_data;
    logic                         rx_empty;
    logic                         rx_frame_error;

    // Command output handshake
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [WIDTH-1:0]             cmd_code;
    logic [3:0]                   cmd_len;
    logic [WIDTH*MAX_PAYLOAD-1:0] cmd_payload;

    // Error strobe
    logic                         err_valid;
    logic [1:0]                   err_code;

    modport master (
        output read_uart,
        input  read_data,
        input  rx_empty,
        input  rx_frame_error,
        output cmd_valid,
        input  cmd_ready,
        output cmd_code,
        output cmd_len,
        output cmd_payload,
        output err_valid,
        output err_code
    );

    modport slave (
        input  read_uart,
        output read_data,
        output rx_empty,
        output rx_frame_error,
        input  cmd_valid,
        output cmd_ready,
        input  cmd_code,
        input  cmd_len,
        input  cmd_payload,
        input  err_valid,
        input  err_code
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// Packet parser behind uart_core's RX FIFO. Pops bytes, assembles
// SOF/CMD/LEN/PAYLOAD/CHK frames, presents checksum-valid commands on a
// valid/ready port and reports malformed packets on a one-cycle error strobe.
// A pop issued in cycle N returns its byte at the edge ending cycle N+2, so a
// three-stage pending pipeline tracks the single outstanding read.
module uart_cmd_parser #(
    parameter int               WIDTH        = 8,
    parameter int               MAX_PAYLOAD  = 8,
    parameter logic [WIDTH-1:0] SOF_BYTE     = 8'hA5,
    parameter int               TIMEOUT_CLKS = 100000
) (
    input  logic              clk,
    input  logic              reset,
    uart_cmd_parser_if.master io_bus
);

    localparam int               PAY_W   = WIDTH * MAX_PAYLOAD;
    localparam int               TO_W    = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [WIDTH-1:0] MAX_LEN = WIDTH'(MAX_PAYLOAD);

    localparam logic [1:0] ERR_CHK     = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_FRAME   = 2'b11;

    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_CMD  = 3'd1,
        ST_LEN  = 3'd2,
        ST_PAY  = 3'd3,
        ST_CHK  = 3'd4,
        ST_OUT  = 3'd5
    } state_t;

    // Running XOR checksum over CMD, LEN and payload bytes.
    function automatic logic [WIDTH-1:0] chk_next(input logic [WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0] data);
        return acc ^ data;
    endfunction

    state_t             r_state;
    logic               r_read_uart;
    logic               r_pend1;
    logic               r_pend2;
    logic               r_drop;
    logic [TO_W-1:0]    r_to_cnt;
    logic [WIDTH-1:0]   r_chk;
    logic [3:0]         r_idx;
    logic [WIDTH-1:0]   r_cmd_code;
    logic [3:0]         r_cmd_len;
    logic [PAY_W-1:0]   r_payload;
    logic               r_cmd_valid;
    logic               r_err_valid;
    logic [1:0]         r_err_code;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_byte;
    logic               w_timed;
    logic               w_frame_abort;
    logic               w_timeout;
    logic               w_cap;
    logic               w_err;
    logic [1:0]         w_err_code;
    logic               w_clr_chk;
    logic               w_acc_chk;
    logic               w_cap_cmd;
    logic               w_cap_len;
    logic               w_cap_pay;
    logic               w_issue;

    assign w_byte        = io_bus.read_data;
    assign w_timed       = (r_state == ST_CMD) || (r_state == ST_LEN) ||
                           (r_state == ST_PAY) || (r_state == ST_CHK);
    assign w_frame_abort = w_timed && io_bus.rx_frame_error;
    assign w_timeout     = w_timed && (r_to_cnt == TO_LAST);
    // A byte arriving after an abort is popped but never interpreted.
    assign w_cap         = r_pend2 && !r_drop && !w_frame_abort && !w_timeout;

    // Next-state and per-byte actions; aborts override any capture result.
    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_err_code  = ERR_CHK;
        w_clr_chk   = 1'b0;
        w_acc_chk   = 1'b0;
        w_cap_cmd   = 1'b0;
        w_cap_len   = 1'b0;
        w_cap_pay   = 1'b0;
        w_issue     = 1'b0;

        case (r_state)
            ST_HUNT: begin
                if (w_cap && (w_byte == SOF_BYTE)) begin
                    w_state_nxt = ST_CMD;
                    w_clr_chk   = 1'b1;
                end else begin
                    w_state_nxt = ST_HUNT;
                end
            end
            ST_CMD: begin
                if (w_cap) begin
                    w_cap_cmd   = 1'b1;
                    w_acc_chk   = 1'b1;
                    w_state_nxt = ST_LEN;
                end else begin
                    w_state_nxt = ST_CMD;
                end
            end
            ST_LEN: begin
                if (w_cap) begin
                    if (w_byte > MAX_LEN) begin
                        w_err       = 1'b1;
                        w_err_code  = ERR_LEN;
                        w_state_nxt = ST_HUNT;
                    end else begin
                        w_cap_len   = 1'b1;
                        w_acc_chk   = 1'b1;
                        w_state_nxt = (w_byte == {WIDTH{1'b0}}) ? ST_CHK : ST_PAY;
                    end
                end else begin
                    w_state_nxt = ST_LEN;
                end
            end
            ST_PAY: begin
                if (w_cap) begin
                    w_cap_pay   = 1'b1;
                    w_acc_chk   = 1'b1;
                    w_state_nxt = (r_idx == (r_cmd_len - 4'd1)) ? ST_CHK : ST_PAY;
                end else begin
                    w_state_nxt = ST_PAY;
                end
            end
            ST_CHK: begin
                if (w_cap) begin
                    if (w_byte == r_chk) begin
                        w_state_nxt = ST_OUT;
                    end else begin
                        w_err       = 1'b1;
                        w_err_code  = ERR_CHK;
                        w_state_nxt = ST_HUNT;
                    end
                end else begin
                    w_state_nxt = ST_CHK;
                end
            end
            ST_OUT: begin
                if (r_cmd_valid && io_bus.cmd_ready) begin
                    w_state_nxt = ST_HUNT;
                end else begin
                    w_state_nxt = ST_OUT;
                end
            end
            default: begin
                w_state_nxt = ST_HUNT;
            end
        endcase

        if (w_frame_abort) begin
            w_err       = 1'b1;
            w_err_code  = ERR_FRAME;
            w_state_nxt = ST_HUNT;
        end else if (w_timeout) begin
            w_err       = 1'b1;
            w_err_code  = ERR_TIMEOUT;
            w_state_nxt = ST_HUNT;
        end else begin
            w_err = w_err;
        end

        // Only the capture-cycle stage may overlap a new pop, keeping one read in flight.
        if ((w_state_nxt != ST_OUT) && !io_bus.rx_empty && !r_read_uart && !r_pend1) begin
            w_issue = 1'b1;
        end else begin
            w_issue = 1'b0;
        end
    end

    // State, read pipeline, timeout counter and error strobe registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_HUNT;
            r_read_uart <= 1'b0;
            r_pend1     <= 1'b0;
            r_pend2     <= 1'b0;
            r_drop      <= 1'b0;
            r_to_cnt    <= {TO_W{1'b0}};
            r_cmd_valid <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_code  <= 2'b00;
        end else begin
            r_state     <= w_state_nxt;
            r_read_uart <= w_issue;
            r_pend1     <= r_read_uart;
            r_pend2     <= r_pend1;
            if (w_err && (r_read_uart || r_pend1)) begin
                r_drop <= 1'b1;
            end else if (r_pend2) begin
                r_drop <= 1'b0;
            end else begin
                r_drop <= r_drop;
            end
            if ((w_state_nxt != r_state) || r_pend2) begin
                r_to_cnt <= {TO_W{1'b0}};
            end else if (w_timed) begin
                r_to_cnt <= r_to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
            end else begin
                r_to_cnt <= {TO_W{1'b0}};
            end
            r_cmd_valid <= (w_state_nxt == ST_OUT);
            r_err_valid <= w_err;
            r_err_code  <= w_err ? w_err_code : 2'b00;
        end
    end

    // Packet assembly: checksum, command fields and payload bytes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_chk      <= {WIDTH{1'b0}};
            r_idx      <= 4'd0;
            r_cmd_code <= {WIDTH{1'b0}};
            r_cmd_len  <= 4'd0;
            r_payload  <= {PAY_W{1'b0}};
        end else begin
            if (w_clr_chk) begin
                r_chk <= {WIDTH{1'b0}};
            end else if (w_acc_chk) begin
                r_chk <= chk_next(r_chk, w_byte);
            end else begin
                r_chk <= r_chk;
            end
            if (w_cap_cmd) begin
                r_cmd_code <= w_byte;
            end
            if (w_cap_len) begin
                r_cmd_len <= w_byte[3:0];
                r_idx     <= 4'd0;
                r_payload <= {PAY_W{1'b0}};
            end else if (w_cap_pay) begin
                r_idx <= r_idx + 4'd1;
                for (int i = 0; i < MAX_PAYLOAD; i++) begin
                    if (r_idx == 4'(i)) begin
                        r_payload[WIDTH*i +: WIDTH] <= w_byte;
                    end
                end
            end
        end
    end

    assign io_bus.read_uart   = r_read_uart;
    assign io_bus.cmd_valid   = r_cmd_valid;
    assign io_bus.cmd_code    = r_cmd_code;
    assign io_bus.cmd_len     = r_cmd_len;
    assign io_bus.cmd_payload = r_payload;
    assign io_bus.err_valid   = r_err_valid;
    assign io_bus.err_code    = r_err_code;

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Downstream consumer of uart_core's host-side RX FIFO interface.
- Pops received bytes and assembles framed command packets: SOF, CMD, LEN, PAYLOAD[LEN], CHK.
- Presents each complete, checksum-valid command on a valid/ready output port, and reports malformed packets on a one-cycle error strobe.
- Sits between uart_core and the application control logic.

Parameters:
- WIDTH, 8, byte width; must match uart_core WIDTH.
- MAX_PAYLOAD, 8, maximum payload bytes per packet (1..15).
- SOF_BYTE, 8'hA5, start-of-frame marker.
- TIMEOUT_CLKS, 100000, inter-byte timeout in clk cycles while a packet is open.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-low; reset is applied when reset=0 at posedge clk.
- read_uart  out  1  one-cycle pop strobe to uart_core RX FIFO.
- read_data  in  WIDTH  RX FIFO data.
- rx_empty  in  1  RX FIFO empty.
- rx_frame_error  in  1  uart_core framing-error pulse.
- cmd_valid  out  1  command available.
- cmd_ready  in  1  consumer accepts command.
- cmd_code  out  WIDTH  CMD byte.
- cmd_len  out  4  payload byte count.
- cmd_payload  out  WIDTH*MAX_PAYLOAD  payload; byte i occupies bits [WIDTH*i+WIDTH-1 : WIDTH*i].
- err_valid  out  1  one-cycle error strobe.
- err_code  out  2  error cause: 00 = checksum, 01 = length, 10 = timeout, 11 = frame error.

Behaviour:
- Reset: all outputs are 0, state = HUNT, timeout counter = 0, checksum accumulator = 0, no read pending.
- Byte fetch: in any fetch state (HUNT, CMD, LEN, PAY, CHK) with rx_empty=0 and no read pending, assert read_uart for exactly one cycle. If read_uart is high in cycle N, read_data is sampled at the posedge ending cycle N+2. At most one read is outstanding. read_uart is never asserted while rx_empty=1.
- HUNT: a captured byte equal to SOF_BYTE goes to CMD and clears the checksum accumulator; any other byte is silently dropped.
- CMD: capture cmd_code; chk ^= byte; go to LEN.
- LEN:
  - If byte > MAX_PAYLOAD: pulse err_code=01 and go to HUNT.
  - Otherwise: capture the length, chk ^= byte, clear cmd_payload to 0, and go to PAY if the length is nonzero, else CHK.
- PAY: store each byte at index 0..len-1; chk ^= byte; after byte len-1, go to CHK.
- CHK:
  - If byte == chk: go to OUT.
  - Otherwise: pulse err_code=00 and go to HUNT.
- OUT:
  - cmd_valid=1. cmd_code, cmd_len and cmd_payload are held stable until cmd_valid && cmd_ready, then go to HUNT.
  - No reads are issued in OUT; bytes back up in the FIFO.
  - Minimum one cycle of cmd_valid; cmd_ready already high on OUT entry completes the transfer in that cycle.
- Timeout:
  - The counter runs only in CMD/LEN/PAY/CHK and clears on every captured byte and on every state entry.
  - When it reaches TIMEOUT_CLKS: pulse err_code=10 and go to HUNT.
- Frame error: rx_frame_error=1 in CMD/LEN/PAY/CHK pulses err_code=11 and goes to HUNT. It is ignored in HUNT and OUT.
- Priority in the same cycle: frame error > timeout > byte-capture result.
- Abort with a read pending: the in-flight byte is still consumed from the FIFO but discarded; HUNT issues no new read until the pending slot clears.
- err_valid is high for exactly one cycle per error; err_code is valid only while err_valid=1 and is 00 otherwise. cmd_valid and err_valid are never high together.
- Reset asserted mid-packet or during OUT: the partial packet is discarded and all outputs return to reset values on the next cycle.

Test Plan:
- Bytes A5 10 02 33 44 65 -> cmd_valid with cmd_code=10, cmd_len=2, cmd_payload[15:0]=4433, upper payload bits 0; no err_valid.
- Bytes 00 FF A5 01 00 01 -> leading garbage dropped; cmd_code=01, cmd_len=0, cmd_payload all 0.
- Bytes A5 10 02 33 44 66 -> err_valid one cycle with err_code=00, no cmd_valid; a following good packet A5 01 00 01 is decoded.
- Bytes A5 20 09 (MAX_PAYLOAD=8) -> err_code=01 right after the LEN capture; the parser resumes hunting at the next byte.
- Bytes A5 10, then line idle > TIMEOUT_CLKS -> err_code=10 exactly TIMEOUT_CLKS cycles after the 0x10 capture; a bad stop bit mid-packet -> err_code=11.
- Two back-to-back good packets with cmd_ready held low 50 cycles -> first command stable for all 50 cycles and read_uart=0 throughout; second command appears after the handshake. Reset low mid-payload -> outputs 0, next packet decoded normally.
